// File: rtl/ddr3_phy_pkg.sv
// Shared DDR3 PHY types: lane-align FSM states and constants.
// Used by the receive lane aligner and its settle timer.
package ddr3_phy_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETTLE,
    ST_COMPARE,
    ST_SLIP,
    ST_MOVE,
    ST_DONE,
    ST_FAIL
  } state_t;

  localparam logic       DIR_INC           = 1'b1;
  localparam logic [7:0] TRAIN_PATTERN_DEF = 8'h0F;
  localparam int         ERR_CNT_W         = 16;

endpackage

// File: rtl/ddr3_rx_settle_timer.sv
// Loadable down-counter with a zero flag for post-pulse waits.
// Ports: clk, rst (sync, active-high), load, value, zero.
module ddr3_rx_settle_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/ddr3_rx_lane_align.sv
// DDR3 read-lane word aligner: bit-slip / delay-step training,
// then forwards registered read data.
// Ports: FAB_CLK, RX_SYNC_RST, START, RX_DATA, DELAY_LINE_OUT_OF_RANGE in;
// slip/load/move pulses, DIRECTION, BUSY/DONE/FAIL, SLIP_CNT,
// MOVE_CNT, RX_DATA_OUT, RX_VALID, ERR_CNT out.
// Macro DDR3_RX_ALIGN_ERRMON_EN builds the post-lock error counter.
module ddr3_rx_lane_align
  import ddr3_phy_pkg::*;
#(
  parameter int                DATA_W        = 8,
  parameter logic [DATA_W-1:0] TRAIN_PATTERN = DATA_W'(TRAIN_PATTERN_DEF),
  parameter int                MATCH_COUNT   = 4,
  parameter int                SLIP_WAIT     = 3,
  parameter int                MAX_MOVES     = 32
) (
  input  logic                           FAB_CLK,
  input  logic                           RX_SYNC_RST,
  input  logic                           START,
  input  logic [DATA_W-1:0]              RX_DATA,
  input  logic                           DELAY_LINE_OUT_OF_RANGE,
  output logic                           RX_BIT_SLIP,
  output logic                           DELAY_LINE_LOAD,
  output logic                           DELAY_LINE_MOVE,
  output logic                           DELAY_LINE_DIRECTION,
  output logic                           BUSY,
  output logic                           DONE,
  output logic                           FAIL,
  output logic [$clog2(DATA_W):0]        SLIP_CNT,
  output logic [$clog2(MAX_MOVES):0]     MOVE_CNT,
  output logic [DATA_W-1:0]              RX_DATA_OUT,
  output logic                           RX_VALID,
  output logic [ERR_CNT_W-1:0]           ERR_CNT
);

  localparam int SW = $clog2(DATA_W) + 1;
  localparam int MW = $clog2(MAX_MOVES) + 1;
  localparam int CW = $clog2(MATCH_COUNT) + 1;
  localparam int TW = $clog2(SLIP_WAIT) + 1;

  state_t        state;
  state_t        state_n;
  logic [SW-1:0] slip_cnt;
  logic [MW-1:0] move_cnt;
  logic [CW-1:0] match_cnt;
  logic          after_move;
  logic          match;
  logic          start_go;
  logic          oor;
  logic          tmr_load;
  logic          tmr_zero;

  assign match    = (RX_DATA == TRAIN_PATTERN);
  assign start_go = START &&
    (state inside {ST_IDLE, ST_DONE, ST_FAIL});
  assign tmr_load = state inside {ST_LOAD, ST_SLIP, ST_MOVE};

  // Limit flag only matters right after a delay step.
  assign oor = DELAY_LINE_OUT_OF_RANGE &&
    ((state == ST_MOVE) ||
     ((state == ST_SETTLE) && after_move));

  ddr3_rx_settle_timer #(
    .W (TW)
  ) u_timer (
    .clk   (FAB_CLK),
    .rst   (RX_SYNC_RST),
    .load  (tmr_load),
    .value (TW'(SLIP_WAIT - 1)),
    .zero  (tmr_zero)
  );

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE,
      ST_DONE,
      ST_FAIL: if (START) state_n = ST_LOAD;
      ST_LOAD: state_n = ST_SETTLE;
      ST_SLIP: state_n = ST_SETTLE;
      ST_MOVE: state_n = oor ? ST_FAIL : ST_SETTLE;
      ST_SETTLE: begin
        if (oor)           state_n = ST_FAIL;
        else if (tmr_zero) state_n = ST_COMPARE;
      end
      ST_COMPARE: begin
        if (match) begin
          if (match_cnt == CW'(MATCH_COUNT - 1))
            state_n = ST_DONE;
        end else if (slip_cnt != SW'(DATA_W - 1)) begin
          state_n = ST_SLIP;
        end else if (move_cnt == MW'(MAX_MOVES)) begin
          state_n = ST_FAIL;
        end else begin
          state_n = ST_MOVE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge FAB_CLK) begin
    if (RX_SYNC_RST) begin
      state      <= ST_IDLE;
      slip_cnt   <= '0;
      move_cnt   <= '0;
      match_cnt  <= '0;
      after_move <= 1'b0;
    end else begin
      state <= state_n;
      if (start_go) begin
        slip_cnt   <= '0;
        move_cnt   <= '0;
        match_cnt  <= '0;
        after_move <= 1'b0;
      end else begin
        if (state_n == ST_SLIP)
          slip_cnt <= slip_cnt + 1'b1;
        else if (state_n == ST_MOVE)
          slip_cnt <= '0;
        if (state_n == ST_MOVE &&
            move_cnt != MW'(MAX_MOVES))
          move_cnt <= move_cnt + 1'b1;
        if (state == ST_SETTLE)
          match_cnt <= '0;
        else if (state == ST_COMPARE && match)
          match_cnt <= match_cnt + 1'b1;
        if (state == ST_MOVE)
          after_move <= 1'b1;
        else if (state_n == ST_COMPARE)
          after_move <= 1'b0;
      end
    end
  end

  always_ff @(posedge FAB_CLK) begin
    if (RX_SYNC_RST) begin
      RX_DATA_OUT <= '0;
      RX_VALID    <= 1'b0;
    end else begin
      RX_DATA_OUT <= RX_DATA;
      RX_VALID    <= (state_n == ST_DONE);
    end
  end

`ifdef DDR3_RX_ALIGN_ERRMON_EN
  logic [ERR_CNT_W-1:0] err_cnt;

  always_ff @(posedge FAB_CLK) begin
    if (RX_SYNC_RST) begin
      err_cnt <= '0;
    end else if (start_go) begin
      err_cnt <= '0;
    end else if (state == ST_DONE && !match &&
                 err_cnt != '1) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end

  assign ERR_CNT = err_cnt;
`else
  assign ERR_CNT = '0;
`endif

  // Pulses are gated by reset so an in-flight pulse dies at once.
  assign RX_BIT_SLIP     = (state == ST_SLIP) && !RX_SYNC_RST;
  assign DELAY_LINE_LOAD = (state == ST_LOAD) && !RX_SYNC_RST;
  assign DELAY_LINE_MOVE = (state == ST_MOVE) && !RX_SYNC_RST;

  assign BUSY = state inside
    {ST_LOAD, ST_SETTLE, ST_COMPARE, ST_SLIP, ST_MOVE};
  assign DONE = (state == ST_DONE);
  assign FAIL = (state == ST_FAIL);
  assign DELAY_LINE_DIRECTION = BUSY & DIR_INC;

  assign SLIP_CNT = slip_cnt;
  assign MOVE_CNT = move_cnt;

endmodule

// File: tb/tb_ddr3_rx_lane_align.sv
// Self-checking bench for ddr3_rx_lane_align with a bit-slip IOD model.
// Expected outcomes and data words are queued and popped on DUT output.
module tb_ddr3_rx_lane_align;

  localparam logic [7:0] PAT  = 8'h0F;
  localparam int         MAXM = 32;
  localparam int         SWT  = 3;

  typedef struct {
    bit fail;
    int slips;
    int moves;
  } res_t;

  logic        FAB_CLK = 1'b0;
  logic        RX_SYNC_RST = 1'b1;
  logic        START = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        OOR = 1'b0;
  logic        RX_BIT_SLIP;
  logic        DELAY_LINE_LOAD;
  logic        DELAY_LINE_MOVE;
  logic        DELAY_LINE_DIRECTION;
  logic        BUSY;
  logic        DONE;
  logic        FAIL;
  logic [3:0]  SLIP_CNT;
  logic [5:0]  MOVE_CNT;
  logic [7:0]  RX_DATA_OUT;
  logic        RX_VALID;
  logic [15:0] ERR_CNT;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int n_slip = 0;
  int n_move = 0;
  int n_load = 0;
  int phase = 0;
  int need = 0;
  int corrupt = 0;
  bit oor_arm = 1'b0;
  int move_cyc = 0;
  int slip_cyc[$];
  logic [7:0] dq[$];
  res_t res_q[$];

  ddr3_rx_lane_align dut (
    .FAB_CLK                 (FAB_CLK),
    .RX_SYNC_RST             (RX_SYNC_RST),
    .START                   (START),
    .RX_DATA                 (rx_data),
    .DELAY_LINE_OUT_OF_RANGE (OOR),
    .RX_BIT_SLIP             (RX_BIT_SLIP),
    .DELAY_LINE_LOAD         (DELAY_LINE_LOAD),
    .DELAY_LINE_MOVE         (DELAY_LINE_MOVE),
    .DELAY_LINE_DIRECTION    (DELAY_LINE_DIRECTION),
    .BUSY                    (BUSY),
    .DONE                    (DONE),
    .FAIL                    (FAIL),
    .SLIP_CNT                (SLIP_CNT),
    .MOVE_CNT                (MOVE_CNT),
    .RX_DATA_OUT             (RX_DATA_OUT),
    .RX_VALID                (RX_VALID),
    .ERR_CNT                 (ERR_CNT)
  );

  always #5 FAB_CLK = ~FAB_CLK;

  function automatic logic [7:0] rotl(
    input logic [7:0] v,
    input int n
  );
    logic [7:0] r;
    r = v;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  // Advance to the next negedge, check data path, run the IOD model.
  task automatic tick();
    logic [7:0] e;
    @(negedge FAB_CLK);
    cyc++;
    if (dq.size() > 0) begin
      e = dq.pop_front();
      n_cmp++;
      if (RX_DATA_OUT !== e) begin
        n_err++;
        $display("FAIL data_out cyc=%0d got=%h exp=%h",
                 cyc, RX_DATA_OUT, e);
      end
    end
    n_cmp++;
    if ($countones({RX_BIT_SLIP, DELAY_LINE_LOAD,
                    DELAY_LINE_MOVE}) > 1) begin
      n_err++;
      $display("FAIL pulse_onehot cyc=%0d got=%b%b%b exp=<=1",
               cyc, RX_BIT_SLIP, DELAY_LINE_LOAD,
               DELAY_LINE_MOVE);
    end
    n_cmp++;
    if (RX_VALID !== DONE) begin
      n_err++;
      $display("FAIL rx_valid cyc=%0d got=%b exp=%b",
               cyc, RX_VALID, DONE);
    end
    if (RX_BIT_SLIP === 1'b1) begin
      phase = (phase + 1) % 8;
      n_slip++;
      slip_cyc.push_back(cyc);
    end
    if (DELAY_LINE_LOAD === 1'b1) n_load++;
    if (DELAY_LINE_MOVE === 1'b1) begin
      n_move++;
      n_cmp++;
      if (DELAY_LINE_DIRECTION !== 1'b1) begin
        n_err++;
        $display("FAIL move_dir cyc=%0d got=%b exp=1",
                 cyc, DELAY_LINE_DIRECTION);
      end
      if (oor_arm) begin
        OOR = 1'b1;
        oor_arm = 1'b0;
        move_cyc = cyc;
      end
    end
    if (corrupt > 0) begin
      rx_data = ~PAT;
      corrupt--;
    end else if (n_move < need) begin
      rx_data = 8'hFF;
    end else begin
      rx_data = rotl(PAT, phase);
    end
    dq.push_back(RX_SYNC_RST ? 8'h00 : rx_data);
  endtask

  task automatic set_rst(input logic v);
    RX_SYNC_RST = v;
    if (dq.size() > 0)
      dq[dq.size()-1] = v ? 8'h00 : rx_data;
  endtask

  // One training run: queue the predicted outcome, then pop and compare.
  task automatic train(
    input int p,
    input int nd,
    input bit arm,
    input bit poke,
    output int lat
  );
    res_t e;
    res_t g;
    phase = p;
    need = nd;
    oor_arm = arm;
    n_slip = 0;
    n_move = 0;
    n_load = 0;
    slip_cyc.delete();
    if (arm) begin
      e.fail = 1'b1; e.slips = 0; e.moves = 1;
    end else if (nd > MAXM) begin
      e.fail = 1'b1; e.slips = 7; e.moves = MAXM;
    end else begin
      e.fail = 1'b0;
      e.moves = nd;
      e.slips = (8 - (p + 7 * nd) % 8) % 8;
    end
    res_q.push_back(e);
    START = 1'b1;
    tick();
    START = 1'b0;
    n_cmp++;
    if ({BUSY, DONE, FAIL} !== 3'b100 || ERR_CNT !== 16'd0) begin
      n_err++;
      $display("FAIL start_clear got=%b%b%b/%0d exp=100/0",
               BUSY, DONE, FAIL, ERR_CNT);
    end
    lat = -1;
    for (int k = 1; k <= 4000; k++) begin
      if (DONE === 1'b1 || FAIL === 1'b1) begin
        lat = k;
        break;
      end
      START = poke && (k == 3);
      tick();
    end
    START = 1'b0;
    g = res_q.pop_front();
    n_cmp++;
    if (lat < 0) begin
      n_err++;
      $display("FAIL train_timeout got=busy exp=done_or_fail");
    end else if (FAIL !== g.fail || DONE !== !g.fail ||
                 SLIP_CNT !== 4'(g.slips) ||
                 MOVE_CNT !== 6'(g.moves)) begin
      n_err++;
      $display("FAIL train_result got=d%b f%b s%0d m%0d exp=f%b s%0d m%0d",
               DONE, FAIL, SLIP_CNT, MOVE_CNT,
               g.fail, g.slips, g.moves);
    end
  endtask

  task automatic test_reset();
    set_rst(1'b1);
    repeat (3) tick();
    n_cmp++;
    if ({RX_BIT_SLIP, DELAY_LINE_LOAD, DELAY_LINE_MOVE,
         DELAY_LINE_DIRECTION, BUSY, DONE, FAIL, RX_VALID} !== 8'd0 ||
        SLIP_CNT !== 4'd0 || MOVE_CNT !== 6'd0 ||
        RX_DATA_OUT !== 8'd0 || ERR_CNT !== 16'd0) begin
      n_err++;
      $display("FAIL reset_outputs got=nonzero exp=all_zero");
    end
    set_rst(1'b0);
    tick();
  endtask

  task automatic test_aligned();
    int lat;
    train(0, 0, 1'b0, 1'b0, lat);
    n_cmp++;
    if (lat != 9) begin
      n_err++;
      $display("FAIL aligned_latency got=%0d exp=9", lat);
    end
    n_cmp++;
    if (n_load != 1 || n_slip != 0) begin
      n_err++;
      $display("FAIL aligned_pulses got=load%0d slip%0d exp=load1 slip0",
               n_load, n_slip);
    end
  endtask

  task automatic test_slip();
    int lat;
    train(5, 0, 1'b0, 1'b1, lat);
    n_cmp++;
    if (n_slip != 3 || n_load != 1) begin
      n_err++;
      $display("FAIL slip_count got=slip%0d load%0d exp=slip3 load1",
               n_slip, n_load);
    end
    // Each gap holds the settle window plus the failing compare.
    for (int i = 1; i < slip_cyc.size(); i++) begin
      n_cmp++;
      if (slip_cyc[i] - slip_cyc[i-1] - 1 != 1 + SWT) begin
        n_err++;
        $display("FAIL slip_gap got=%0d exp=%0d",
                 slip_cyc[i] - slip_cyc[i-1] - 1, 1 + SWT);
      end
    end
  endtask

  task automatic test_move();
    int lat;
    train(0, 2, 1'b0, 1'b0, lat);
    n_cmp++;
    if (n_move != 2) begin
      n_err++;
      $display("FAIL move_pulses got=%0d exp=2", n_move);
    end
  endtask

  task automatic test_errmon();
    int lat;
    logic [15:0] exp_err;
`ifdef DDR3_RX_ALIGN_ERRMON_EN
    exp_err = 16'd3;
`else
    exp_err = 16'd0;
`endif
    train(0, 0, 1'b0, 1'b0, lat);
    corrupt = 3;
    repeat (6) tick();
    n_cmp++;
    if (ERR_CNT !== exp_err || DONE !== 1'b1 || RX_VALID !== 1'b1) begin
      n_err++;
      $display("FAIL errmon got=err%0d done%b exp=err%0d done1",
               ERR_CNT, DONE, exp_err);
    end
  endtask

  task automatic test_oor();
    int lat;
    train(0, 1000, 1'b1, 1'b0, lat);
    n_cmp++;
    if (cyc != move_cyc + 1) begin
      n_err++;
      $display("FAIL oor_timing got=%0d exp=%0d", cyc, move_cyc + 1);
    end
    OOR = 1'b0;
  endtask

  task automatic test_fail();
    int lat;
    int s0;
    int m0;
    int l0;
    train(0, 1000, 1'b0, 1'b0, lat);
    s0 = n_slip;
    m0 = n_move;
    l0 = n_load;
    repeat (20) tick();
    n_cmp++;
    if (n_slip != s0 || n_move != m0 || n_load != l0 ||
        BUSY !== 1'b0 || FAIL !== 1'b1 || DONE !== 1'b0) begin
      n_err++;
      $display("FAIL fail_hold got=busy%b fail%b pulses%0d exp=busy0 fail1 pulses0",
               BUSY, FAIL, n_slip + n_move + n_load - s0 - m0 - l0);
    end
  endtask

  task automatic test_reset_mid_slip();
    int lat;
    bit seen;
    phase = 3;
    need = 0;
    n_slip = 0;
    n_move = 0;
    seen = 1'b0;
    START = 1'b1;
    tick();
    START = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (RX_BIT_SLIP === 1'b1) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    n_cmp++;
    if (!seen) begin
      n_err++;
      $display("FAIL mid_slip_reach got=no_slip exp=slip");
    end else begin
      phase = (phase + 7) % 8;
      set_rst(1'b1);
      #1;
      n_cmp++;
      if (RX_BIT_SLIP !== 1'b0) begin
        n_err++;
        $display("FAIL slip_drop got=%b exp=0", RX_BIT_SLIP);
      end
      tick();
      n_cmp++;
      if ({RX_BIT_SLIP, DELAY_LINE_LOAD, DELAY_LINE_MOVE,
           DELAY_LINE_DIRECTION, BUSY, DONE, FAIL, RX_VALID} !== 8'd0 ||
          SLIP_CNT !== 4'd0 || MOVE_CNT !== 6'd0 ||
          RX_DATA_OUT !== 8'd0) begin
        n_err++;
        $display("FAIL mid_slip_reset got=busy%b slip%0d exp=all_zero",
                 BUSY, SLIP_CNT);
      end
      set_rst(1'b0);
      tick();
    end
    train(3, 0, 1'b0, 1'b0, lat);
  endtask

  initial begin
    test_reset();
    test_aligned();
    test_slip();
    test_move();
    test_errmon();
    test_oor();
    test_fail();
    test_reset_mid_slip();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ddr3_rx_lane_align.md
Name: ddr3_rx_lane_align

Overview:
Receive-side companion to the DDR3 PHY output IODs. It sits between one read-lane IOD deserializer and the fabric. It trains word alignment by pulsing RX_BIT_SLIP until the deserialized word matches a training pattern. Once every slip phase has been tried, it steps the IOD delay line. After lock it forwards aligned read data to the controller.

Parameters:
DATA_W, 8, deserialized word width per FAB_CLK (4:1 DDR gearing)
TRAIN_PATTERN, 8'h0F, expected aligned training word
MATCH_COUNT, 4, consecutive matching words required for lock
SLIP_WAIT, 3, settle cycles after each slip/load/move pulse
MAX_MOVES, 32, delay-line steps allowed before FAIL

Ports:
FAB_CLK  input  1  fabric clock; all logic on rising edge
RX_SYNC_RST  input  1  synchronous, active-high reset
START  input  1  one-cycle training request
RX_DATA  input  DATA_W  deserialized word from IOD
DELAY_LINE_OUT_OF_RANGE  input  1  IOD delay-line limit flag
RX_BIT_SLIP  output  1  one-cycle slip pulse to IOD
DELAY_LINE_LOAD  output  1  one-cycle load pulse (restores default delay)
DELAY_LINE_MOVE  output  1  one-cycle delay step pulse
DELAY_LINE_DIRECTION  output  1  step direction; constant 1 (increment) while BUSY
BUSY  output  1  training in progress
DONE  output  1  lock achieved; held until START or reset
FAIL  output  1  training failed; held until START or reset
SLIP_CNT  output  $clog2(DATA_W)+1  slips since last move
MOVE_CNT  output  $clog2(MAX_MOVES)+1  delay steps taken
RX_DATA_OUT  output  DATA_W  registered RX_DATA
RX_VALID  output  1  high while DONE; qualifies RX_DATA_OUT
ERR_CNT  output  16  post-lock mismatch count (optional feature)

Behaviour:
- Reset: every output is 0; the FSM goes to IDLE. Reset mid-training drops any pulse in the same cycle.
- States: IDLE, LOAD, SETTLE, COMPARE, SLIP, MOVE, DONE, FAIL.
- IDLE/DONE/FAIL + START -> LOAD. The slip, move and match counters clear, and DONE, FAIL and ERR_CNT clear.
- START is ignored while BUSY.
- LOAD: DELAY_LINE_LOAD=1 for exactly one cycle -> SETTLE.
- SETTLE: wait counter runs SLIP_WAIT cycles -> COMPARE. The match counter clears on entry.
- COMPARE on RX_DATA==TRAIN_PATTERN: match counter increments. On reaching MATCH_COUNT -> DONE.
- COMPARE on mismatch with SLIP_CNT<DATA_W-1 -> SLIP. RX_BIT_SLIP=1 for one cycle, SLIP_CNT+1, then SETTLE.
- COMPARE on mismatch with SLIP_CNT==DATA_W-1 (all phases exhausted):
  - MOVE_CNT==MAX_MOVES -> FAIL.
  - Otherwise -> MOVE: DELAY_LINE_MOVE=1 for one cycle, MOVE_CNT+1, SLIP_CNT=0, then SETTLE.
- DELAY_LINE_OUT_OF_RANGE sampled high in MOVE or in the SETTLE that follows a MOVE -> FAIL immediately. This takes priority over a COMPARE transition.
- At most one of RX_BIT_SLIP, DELAY_LINE_LOAD, DELAY_LINE_MOVE is high in any cycle.
- BUSY=1 in LOAD, SETTLE, COMPARE, SLIP and MOVE.
- DONE and FAIL are mutually exclusive and assert the cycle after the deciding compare.
- Aligned-at-start latency: START in cycle 0 -> LOAD in cycle 1 -> SETTLE in cycles 2-4 -> matches in cycles 5-8 -> DONE=1 in cycle 9.
- RX_DATA_OUT registers RX_DATA every cycle (1-cycle latency).
- RX_VALID = DONE, registered alongside RX_DATA_OUT.
- Counters never wrap. MOVE_CNT saturates at MAX_MOVES.

Optional Feature:
DDR3_RX_ALIGN_ERRMON_EN
- Defined: in DONE, each RX_DATA != TRAIN_PATTERN increments ERR_CNT, saturating at 16'hFFFF. ERR_CNT clears on START or reset. DONE is not dropped.
- Undefined: ERR_CNT is tied to 0 and no counter logic is built.

Decomposition:
- Shared package ddr3_phy_pkg holds:
  - the FSM state enum;
  - the DIR_INC constant;
  - the default TRAIN_PATTERN;
  - the ERR_CNT width constant.
- One natural sub-module: ddr3_rx_settle_timer, a loadable down-counter with a zero flag, reused for every post-pulse wait.

Test Plan:
- Bench IOD model rotates TRAIN_PATTERN left by a phase; each RX_BIT_SLIP advances the phase by 1.
- Phase 0, START -> DONE in cycle 9, SLIP_CNT=0, MOVE_CNT=0, exactly one DELAY_LINE_LOAD pulse.
- Phase 5 -> exactly 3 RX_BIT_SLIP pulses, each 1+SLIP_WAIT cycles apart; DONE with SLIP_CNT=3.
- Data invalid until 2 delay steps (model returns 8'hFF before that) -> 2 DELAY_LINE_MOVE pulses with DIRECTION=1; DONE with MOVE_CNT=2.
- Data never valid -> FAIL with MOVE_CNT=32, BUSY=0, no further pulses.
- DELAY_LINE_OUT_OF_RANGE=1 after the first MOVE -> FAIL on that cycle.
- Reset mid-SLIP -> all outputs 0 next cycle; a new START retrains normally.
- With DDR3_RX_ALIGN_ERRMON_EN, inject 3 corrupted words after DONE -> ERR_CNT=3 and DONE stays 1.
